dccm_arbiter: RTL
=================

Name: dccm_arbiter

Overview:
- Sequences and shares the byte-addressed data memory (DCCM) between two requesters: port 0 = core load/store unit, port 1 = program/data loader (UART boot path).
- Round-robin arbitration, valid/ready request handshake, registered response with load sign/zero extension, and misalignment/illegal-func_3 error flagging.
- Sits between the pipeline MEM stage / loader and the DCCM memory-side ports.

Parameters:
- DataWidth, 32, data bus width; only 32 supported.
- AddrWidth, 10, byte address width; matches the DCCM depth of 2**AddrWidth bytes.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- rq_valid  in  2  per-port request valid; bit0 = core, bit1 = loader.
- rq_ready  out  2  per-port accept strobe; one-hot or zero.
- rq_we  in  2  per-port 1 = store, 0 = load.
- rq_func3_0 / rq_func3_1  in  3 each  RISC-V funct3 per port.
- rq_addr_0 / rq_addr_1  in  AddrWidth each  byte address per port.
- rq_wdata_0 / rq_wdata_1  in  DataWidth each  store data per port.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_rdata  out  DataWidth  extended load data, shared by both ports; zero for stores.
- rsp_err  out  1  response carries an error (misaligned or illegal funct3).
- mem_readEn  out  1  DCCM read enable.
- mem_writeEn  out  1  DCCM write enable.
- mem_func3  out  3  DCCM funct3.
- mem_addr  out  AddrWidth  DCCM byte address.
- mem_datain  out  DataWidth  DCCM write data.
- mem_dataout  in  DataWidth  DCCM combinational read data; width bytes valid per funct3.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE; rr_last = 1, so port 0 wins the first conflict.
  - rq_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - All mem_* outputs = 0.
- FSM has three states: IDLE, ACCESS, RESP. A single request is in flight at a time.
- IDLE:
  - If any rq_valid bit is set, grant one port. A single requester always wins. On a conflict, the port other than rr_last wins.
  - rq_ready[g] = 1 in the same cycle, combinational from rq_valid and state.
  - Latch we, funct3, addr, wdata and owner g; go to ACCESS.
  - No rq_valid set: stay in IDLE.
- Legality check, done at latch:
  - Legal stores: funct3 000 (sb), 001 (sh), 010 (sw).
  - Legal loads: funct3 000 (lb), 001 (lh), 010 (lw), 100 (lbu), 101 (lhu).
  - Any other funct3 is illegal.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal or misaligned sets err_q.
- ACCESS (exactly one cycle):
  - If err_q = 0: drive mem_addr, mem_func3 and mem_datain from the latches. Assert mem_writeEn for a store or mem_readEn for a load.
  - If err_q = 1: both enables stay 0, so memory is untouched.
  - For a legal load, register the extended data into rsp_rdata at the end of the cycle:
    - lb: sign-extend bits [7:0].
    - lbu: zero-extend bits [7:0].
    - lh: sign-extend bits [15:0].
    - lhu: zero-extend bits [15:0].
    - lw: bits [31:0] unchanged.
  - Store or error: rsp_rdata = 0.
  - Go to RESP.
- Outside ACCESS, mem_readEn = mem_writeEn = 0.
- RESP:
  - rsp_valid[owner] = 1; rsp_err = err_q. rsp_rdata and rsp_err stay stable while waiting.
  - On rsp_ready[owner] = 1: rr_last <= owner, go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
  - New requests are not accepted in RESP.
- Latency:
  - Accept at cycle T; memory access at T+1; rsp_valid first high at T+2.
  - Best-case throughput is one request per 3 cycles.
- Stalls: a requester holds its request stable while rq_ready = 0. Its valid may drop without penalty.
- Reset in ACCESS or RESP: the in-flight request is abandoned and no response is given. A write in ACCESS whose reset edge coincides with the write edge still commits, because the enable was already asserted during that cycle.

Test Plan:
- Reset, then core sw addr 0x010, data 0xDEADBEEF -> rq_ready[0] in cycle T; mem_writeEn=1, funct3=010 at T+1; rsp_valid[0] at T+2; rsp_err=0.
- Core lb 0x013 after the above -> rsp_rdata=0xFFFFFFDE. lbu 0x013 -> 0x000000DE. lh 0x012 -> 0xFFFFDEAD. lw 0x010 -> 0xDEADBEEF.
- Both ports valid every cycle, responses accepted immediately -> grants alternate 0,1,0,1. The first grant after reset goes to port 0.
- Loader sh at 0x021 -> rsp_err=1, mem_writeEn never asserted. A following lw 0x020 returns the prior contents unchanged. Load funct3=011 -> rsp_err=1.
- Hold rsp_ready[1]=0 for 5 cycles during RESP with core valid -> rsp_valid[1] and rsp_rdata stable, rq_ready[0]=0 throughout. Core is granted the cycle after the handshake.
- Assert reset during ACCESS of a load -> the next cycle is IDLE, all outputs 0, no rsp_valid is produced.

Source files
------------

// File: rtl/dccm_arbiter.sv
// Two-port round-robin arbiter in front of the byte-addressed DCCM: one request in flight,
// registered memory controls, registered extended load response with error flagging.
module dccm_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           rq_valid,
    output logic [1:0]           rq_ready,
    input  logic [1:0]           rq_we,
    input  logic [2:0]           rq_func3_0,
    input  logic [2:0]           rq_func3_1,
    input  logic [AddrWidth-1:0] rq_addr_0,
    input  logic [AddrWidth-1:0] rq_addr_1,
    input  logic [DataWidth-1:0] rq_wdata_0,
    input  logic [DataWidth-1:0] rq_wdata_1,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_readEn,
    output logic                 mem_writeEn,
    output logic [2:0]           mem_func3,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_datain,
    input  logic [DataWidth-1:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e               state_q;
    logic                 rr_last_q;
    logic                 owner_q;
    logic                 we_q;
    logic [2:0]           func3_q;
    logic                 err_q;
    logic [1:0]           rsp_valid_q;
    logic [DataWidth-1:0] rsp_rdata_q;
    logic                 rsp_err_q;
    logic                 mem_readEn_q;
    logic                 mem_writeEn_q;
    logic [2:0]           mem_func3_q;
    logic [AddrWidth-1:0] mem_addr_q;
    logic [DataWidth-1:0] mem_datain_q;

    logic [1:0]           grant;
    logic                 sel_port;
    logic                 sel_we;
    logic [2:0]           sel_func3;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic                 sel_illegal;
    logic                 sel_misalign;
    logic                 sel_err;
    logic [DataWidth-1:0] load_ext;

    // Grant is combinational so the requester sees rq_ready in the cycle it is accepted;
    // on a conflict the port that did not own the last completed request wins.
    always_comb begin
        grant = '0;
        if (state_q == IDLE && !reset) begin
            case (rq_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    assign sel_port  = grant[1];
    assign sel_we    = rq_we[sel_port];
    assign sel_func3 = sel_port ? rq_func3_1 : rq_func3_0;
    assign sel_addr  = sel_port ? rq_addr_1  : rq_addr_0;
    assign sel_wdata = sel_port ? rq_wdata_1 : rq_wdata_0;

    always_comb begin
        sel_illegal  = 1'b0;
        sel_misalign = 1'b0;
        case (sel_func3)
            3'b000: sel_misalign = 1'b0;
            3'b001: sel_misalign = sel_addr[0];
            3'b010: sel_misalign = |sel_addr[1:0];
            3'b100: sel_illegal  = sel_we;
            3'b101: begin
                sel_illegal  = sel_we;
                sel_misalign = sel_addr[0];
            end
            default: sel_illegal = 1'b1;
        endcase
    end

    assign sel_err = sel_illegal | sel_misalign;

    always_comb begin
        load_ext = '0;
        case (func3_q)
            3'b000:  load_ext = {{(DataWidth-8){mem_dataout[7]}}, mem_dataout[7:0]};
            3'b001:  load_ext = {{(DataWidth-16){mem_dataout[15]}}, mem_dataout[15:0]};
            3'b010:  load_ext = mem_dataout;
            3'b100:  load_ext = {{(DataWidth-8){1'b0}}, mem_dataout[7:0]};
            3'b101:  load_ext = {{(DataWidth-16){1'b0}}, mem_dataout[15:0]};
            default: load_ext = '0;
        endcase
    end

    // Memory controls are loaded at the accept edge so they are high for exactly the
    // ACCESS cycle; they default back to zero on every other edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            owner_q       <= 1'b0;
            we_q          <= 1'b0;
            func3_q       <= '0;
            err_q         <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            mem_readEn_q  <= 1'b0;
            mem_writeEn_q <= 1'b0;
            mem_func3_q   <= '0;
            mem_addr_q    <= '0;
            mem_datain_q  <= '0;
        end else begin
            mem_readEn_q  <= 1'b0;
            mem_writeEn_q <= 1'b0;
            mem_func3_q   <= '0;
            mem_addr_q    <= '0;
            mem_datain_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        owner_q <= sel_port;
                        we_q    <= sel_we;
                        func3_q <= sel_func3;
                        err_q   <= sel_err;
                        if (!sel_err) begin
                            mem_writeEn_q <= sel_we;
                            mem_readEn_q  <= ~sel_we;
                            mem_func3_q   <= sel_func3;
                            mem_addr_q    <= sel_addr;
                            mem_datain_q  <= sel_wdata;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_rdata_q <= (!we_q && !err_q) ? load_ext : '0;
                    rsp_err_q   <= err_q;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rr_last_q   <= owner_q;
                        rsp_valid_q <= '0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rq_ready    = grant;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_readEn  = mem_readEn_q;
    assign mem_writeEn = mem_writeEn_q;
    assign mem_func3   = mem_func3_q;
    assign mem_addr    = mem_addr_q;
    assign mem_datain  = mem_datain_q;

endmodule
